// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: CPU has fixed priority,
// DMA gets a forced grant after MAX_WAIT blocked cycles; read data is tagged to its owner.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              CpuReq,
  input  logic              CpuWe,
  input  logic [ADDR_W-1:0] CpuAddr,
  input  logic [DATA_W-1:0] CpuWrData,
  output logic              CpuGnt,
  output logic              CpuStall,
  output logic              CpuRdValid,
  output logic [DATA_W-1:0] CpuRdData,
  input  logic              DmaReq,
  input  logic              DmaWe,
  input  logic [ADDR_W-1:0] DmaAddr,
  input  logic [DATA_W-1:0] DmaWrData,
  output logic              DmaGnt,
  output logic              DmaRdValid,
  output logic [DATA_W-1:0] DmaRdData,
  output logic [ADDR_W-1:0] DmemAddr,
  output logic              DmemWrite,
  output logic [DATA_W-1:0] DmemWrData,
  input  logic [DATA_W-1:0] DmemRdData
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_DMA
  } owner_t;

  localparam logic [CNT_W-1:0] MaxWaitC = CNT_W'(MAX_WAIT);

  owner_t           RdOwner;
  logic [CNT_W-1:0] WaitCnt;
  logic             Force;

  always_comb begin
    Force    = DmaReq && (WaitCnt >= MaxWaitC);
    DmaGnt   = DmaReq & (~CpuReq | Force);
    CpuGnt   = CpuReq & ~DmaGnt;
    CpuStall = CpuReq & ~CpuGnt;
    if (DmaGnt) begin
      DmemAddr   = DmaAddr;
      DmemWrData = DmaWrData;
      DmemWrite  = DmaWe;
    end else begin
      DmemAddr   = CpuAddr;
      DmemWrData = CpuWrData;
      DmemWrite  = CpuGnt & CpuWe;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      WaitCnt <= '0;
      RdOwner <= OWN_NONE;
    end else begin
      if (DmaGnt || !DmaReq)
        WaitCnt <= '0;
      else if (WaitCnt < MaxWaitC)
        WaitCnt <= WaitCnt + CNT_W'(1);

      if (CpuGnt && !CpuWe)
        RdOwner <= OWN_CPU;
      else if (DmaGnt && !DmaWe)
        RdOwner <= OWN_DMA;
      else
        RdOwner <= OWN_NONE;
    end
  end

  // Valids decode the registered owner; data is passed through and qualified by them.
  assign CpuRdValid = (RdOwner == OWN_CPU);
  assign DmaRdValid = (RdOwner == OWN_DMA);
  assign CpuRdData  = DmemRdData;
  assign DmaRdData  = DmemRdData;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a registered read-before-write memory model.
module tb_dmem_arbiter;

  logic        Clk;
  logic        Rst_n;
  logic        CpuReq, CpuWe, DmaReq, DmaWe;
  logic [31:0] CpuAddr, CpuWrData, DmaAddr, DmaWrData;
  logic        CpuGnt, CpuStall, CpuRdValid, DmaGnt, DmaRdValid, DmemWrite;
  logic [31:0] CpuRdData, DmaRdData, DmemAddr, DmemWrData, DmemRdData;

  logic        bdWe;
  logic [9:0]  bdAddr;
  logic [31:0] bdData;
  logic [31:0] mem [0:1023];

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4), .CNT_W(3)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .CpuReq(CpuReq), .CpuWe(CpuWe), .CpuAddr(CpuAddr), .CpuWrData(CpuWrData),
    .CpuGnt(CpuGnt), .CpuStall(CpuStall), .CpuRdValid(CpuRdValid), .CpuRdData(CpuRdData),
    .DmaReq(DmaReq), .DmaWe(DmaWe), .DmaAddr(DmaAddr), .DmaWrData(DmaWrData),
    .DmaGnt(DmaGnt), .DmaRdValid(DmaRdValid), .DmaRdData(DmaRdData),
    .DmemAddr(DmemAddr), .DmemWrite(DmemWrite), .DmemWrData(DmemWrData),
    .DmemRdData(DmemRdData)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Data memory model: registered read, read-before-write, plus a preload port.
  always @(posedge Clk) begin
    DmemRdData <= mem[DmemAddr[9:0]];
    if (bdWe)
      mem[bdAddr] <= bdData;
    else if (DmemWrite)
      mem[DmemAddr[9:0]] <= DmemWrData;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic cwe, input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dwe, input logic [31:0] da, input logic [31:0] dd);
    @(negedge Clk);
    CpuReq = cr; CpuWe = cwe; CpuAddr = ca; CpuWrData = cd;
    DmaReq = dr; DmaWe = dwe; DmaAddr = da; DmaWrData = dd;
    #1;
  endtask

  task automatic afterEdge();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst_n = 1'b0;
    bdWe = 1'b0; bdAddr = '0; bdData = '0;
    CpuReq = 1'b0; CpuWe = 1'b0; CpuAddr = '0; CpuWrData = '0;
    DmaReq = 1'b0; DmaWe = 1'b0; DmaAddr = '0; DmaWrData = '0;

    // Reset state and memory preload
    #1;
    chk("rst_cpugnt", CpuGnt, 1'b0);
    chk("rst_dmagnt", DmaGnt, 1'b0);
    chk("rst_cpuvalid", CpuRdValid, 1'b0);
    chk("rst_dmavalid", DmaRdValid, 1'b0);
    chk("rst_dmemwrite", DmemWrite, 1'b0);
    chk("rst_waitcnt", dut.WaitCnt, 3'd0);
    @(negedge Clk); bdWe = 1'b1; bdAddr = 10'h010; bdData = 32'hDEADBEEF;
    @(negedge Clk); bdAddr = 10'h011; bdData = 32'h11111111;
    @(negedge Clk); bdWe = 1'b0;
    Rst_n = 1'b1;

    // 1: CPU-only load
    drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
    chk("t1_cpugnt", CpuGnt, 1'b1);
    chk("t1_stall", CpuStall, 1'b0);
    chk("t1_addr", DmemAddr, 32'h10);
    chk("t1_we", DmemWrite, 1'b0);
    afterEdge();
    chk("t1_cpuvalid", CpuRdValid, 1'b1);
    chk("t1_cpudata", CpuRdData, 32'hDEADBEEF);
    chk("t1_dmavalid", DmaRdValid, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_idle_gnt", CpuGnt, 1'b0);
    afterEdge();
    chk("t1_valid_drop", CpuRdValid, 1'b0);

    // 2: DMA-only write then read
    drive(0, 0, 0, 0, 1, 1, 32'h20, 32'h5);
    chk("t2_dmagnt_w", DmaGnt, 1'b1);
    chk("t2_we", DmemWrite, 1'b1);
    chk("t2_addr", DmemAddr, 32'h20);
    chk("t2_wdata", DmemWrData, 32'h5);
    chk("t2_stall_w", CpuStall, 1'b0);
    afterEdge();
    chk("t2_novalid_w", DmaRdValid, 1'b0);
    drive(0, 0, 0, 0, 1, 0, 32'h20, 0);
    chk("t2_dmagnt_r", DmaGnt, 1'b1);
    chk("t2_we_r", DmemWrite, 1'b0);
    chk("t2_stall_r", CpuStall, 1'b0);
    afterEdge();
    chk("t2_dmavalid", DmaRdValid, 1'b1);
    chk("t2_dmadata", DmaRdData, 32'h5);
    chk("t2_cpuvalid", CpuRdValid, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    afterEdge();

    // 3: both requesting continuously -> 4 CPU grants, 1 forced DMA grant
    for (int k = 0; k < 10; k++) begin
      logic expDma;
      expDma = ((k % 5) == 4);
      drive(1, 0, 32'h10, 0, 1, 0, 32'h11, 0);
      chk($sformatf("t3_dmagnt_%0d", k), DmaGnt, expDma);
      chk($sformatf("t3_cpugnt_%0d", k), CpuGnt, !expDma);
      chk($sformatf("t3_stall_%0d", k), CpuStall, expDma);
      afterEdge();
      chk($sformatf("t3_cpuvalid_%0d", k), CpuRdValid, !expDma);
      chk($sformatf("t3_dmavalid_%0d", k), DmaRdValid, expDma);
      chk($sformatf("t3_data_%0d", k), CpuRdData, expDma ? 32'h11111111 : 32'hDEADBEEF);
      chk($sformatf("t3_waitcnt_%0d", k), dut.WaitCnt, expDma ? 32'd0 : 32'(k % 5 + 1));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    afterEdge();
    chk("t3_waitcnt_clr", dut.WaitCnt, 3'd0);

    // 4: same-cycle CPU store beats DMA read; DMA read follows and sees the store
    drive(1, 1, 32'h30, 32'hA, 1, 0, 32'h30, 0);
    chk("t4_cpugnt", CpuGnt, 1'b1);
    chk("t4_dmagnt", DmaGnt, 1'b0);
    chk("t4_we", DmemWrite, 1'b1);
    chk("t4_wdata", DmemWrData, 32'hA);
    afterEdge();
    chk("t4_novalid", CpuRdValid | DmaRdValid, 1'b0);
    drive(0, 0, 0, 0, 1, 0, 32'h30, 0);
    chk("t4_dmagnt2", DmaGnt, 1'b1);
    chk("t4_addr2", DmemAddr, 32'h30);
    afterEdge();
    chk("t4_dmavalid", DmaRdValid, 1'b1);
    chk("t4_dmadata", DmaRdData, 32'hA);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    afterEdge();

    // 5: reset right after a CPU read grant drops the pending valid
    drive(1, 0, 32'h10, 0, 1, 0, 32'h11, 0);
    chk("t5_cpugnt", CpuGnt, 1'b1);
    @(posedge Clk);
    #1;
    Rst_n = 1'b0;
    CpuReq = 1'b0; DmaReq = 1'b0;
    #1;
    chk("t5_rst_valid", CpuRdValid, 1'b0);
    chk("t5_rst_waitcnt", dut.WaitCnt, 3'd0);
    afterEdge();
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    chk("t5_idle_cpugnt", CpuGnt, 1'b0);
    chk("t5_idle_dmagnt", DmaGnt, 1'b0);
    afterEdge();
    chk("t5_post_cpuvalid", CpuRdValid, 1'b0);
    chk("t5_post_dmavalid", DmaRdValid, 1'b0);
    afterEdge();
    chk("t5_post2_cpuvalid", CpuRdValid, 1'b0);

    // 6: DMA blocked for 2 cycles then withdraws
    drive(1, 0, 32'h10, 0, 1, 1, 32'h40, 32'h77);
    chk("t6_dmagnt1", DmaGnt, 1'b0);
    afterEdge();
    chk("t6_waitcnt1", dut.WaitCnt, 3'd1);
    drive(1, 0, 32'h10, 0, 1, 1, 32'h40, 32'h77);
    chk("t6_dmagnt2", DmaGnt, 1'b0);
    chk("t6_we2", DmemWrite, 1'b0);
    afterEdge();
    chk("t6_waitcnt2", dut.WaitCnt, 3'd2);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_dmagnt3", DmaGnt, 1'b0);
    afterEdge();
    chk("t6_waitcnt3", dut.WaitCnt, 3'd0);
    chk("t6_dmavalid", DmaRdValid, 1'b0);
    chk("t6_mem_untouched", mem[10'h040] === 32'h77, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
